// File: rtl/ibuf_port_arbiter_if.sv
// Requester, read-return and buffer-command signals of the input feature buffer arbiter.
// slave = arbiter side, master = requester/buffer side.
interface ibuf_port_arbiter_if #(
    parameter int unsigned COLW = 28,
    parameter int unsigned DW   = 64
);
    logic            wr_req;
    logic [1:0]      wr_bank;
    logic [1:0]      wr_row;
    logic [COLW-1:0] wr_col;
    logic [DW-1:0]   wr_data;
    logic            wr_last;
    logic            wr_gnt;

    logic            rd_req;
    logic [1:0]      rd_rpsel;
    logic [1:0]      rd_bank;
    logic [1:0]      rd_row;
    logic [COLW-1:0] rd_col;
    logic            rd_gnt;
    logic            rd_rvalid;
    logic [1:0]      rd_rpsel_o;
    logic [DW-1:0]   rd_rdata;
    logic            blkend;

    logic            buf_en;
    logic            buf_we;
    logic [1:0]      buf_bank;
    logic [1:0]      buf_row;
    logic [COLW-1:0] buf_col;
    logic [DW-1:0]   buf_wdata;
    logic [DW-1:0]   buf_rdata;

    modport slave (
        input  wr_req, wr_bank, wr_row, wr_col, wr_data, wr_last,
        output wr_gnt,
        input  rd_req, rd_rpsel, rd_bank, rd_row, rd_col,
        output rd_gnt, rd_rvalid, rd_rpsel_o, rd_rdata, blkend,
        output buf_en, buf_we, buf_bank, buf_row, buf_col, buf_wdata,
        input  buf_rdata
    );

    modport master (
        output wr_req, wr_bank, wr_row, wr_col, wr_data, wr_last,
        input  wr_gnt,
        output rd_req, rd_rpsel, rd_bank, rd_row, rd_col,
        input  rd_gnt, rd_rvalid, rd_rpsel_o, rd_rdata, blkend,
        input  buf_en, buf_we, buf_bank, buf_row, buf_col, buf_wdata,
        output buf_rdata
    );
endinterface

// File: rtl/ibuf_port_arbiter.sv
// Single-port input feature buffer arbiter: read priority with forced write bursts
// against starvation, registered buffer command, tagged fixed-latency read return.
module ibuf_port_arbiter #(
    parameter int unsigned RD_LAT   = 3,
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned WBURST   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    ibuf_port_arbiter_if.slave bus
);
    localparam int unsigned WCW = $clog2(MAX_WAIT + 1);
    localparam int unsigned BCW = $clog2(WBURST) + 1;

    typedef enum logic {RD_PRI, WR_BURST} state_t;

    state_t               state, state_nx;
    logic [WCW-1:0]       wait_cnt, wait_nx;
    logic [BCW-1:0]       burst_cnt, burst_nx;
    logic                 wr_gnt_c, rd_gnt_c, starve;
    logic [RD_LAT-1:0]    vpipe;
    logic [RD_LAT-1:0][1:0] tpipe;
    logic                 wlast_q;

    // Arbitration and next state; the cycle that flips to WR_BURST grants nobody.
    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        burst_nx = burst_cnt;
        wr_gnt_c = 1'b0;
        rd_gnt_c = 1'b0;
        starve   = 1'b0;
        case (state)
            RD_PRI: begin
                starve   = bus.wr_req && (wait_cnt == WCW'(MAX_WAIT));
                rd_gnt_c = bus.rd_req && !starve;
                wr_gnt_c = bus.wr_req && !bus.rd_req && !starve;
                if (starve) begin
                    state_nx = WR_BURST;
                    burst_nx = '0;
                    wait_nx  = '0;
                end else if (wr_gnt_c || !bus.wr_req) begin
                    wait_nx = '0;
                end else begin
                    wait_nx = wait_cnt + WCW'(1);
                end
            end
            WR_BURST: begin
                wr_gnt_c = bus.wr_req;
                rd_gnt_c = bus.rd_req && !bus.wr_req;
                wait_nx  = '0;
                if (!bus.wr_req) begin
                    state_nx = RD_PRI;
                end else begin
                    burst_nx = burst_cnt + BCW'(1);
                    if (bus.wr_last || (burst_cnt == BCW'(WBURST - 1))) state_nx = RD_PRI;
                end
            end
            default: state_nx = RD_PRI;
        endcase
    end

    assign bus.wr_gnt = wr_gnt_c;
    assign bus.rd_gnt = rd_gnt_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RD_PRI;
            wait_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            burst_cnt <= burst_nx;
        end
    end

    // Buffer command register; fields hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.buf_en    <= 1'b0;
            bus.buf_we    <= 1'b0;
            bus.buf_bank  <= '0;
            bus.buf_row   <= '0;
            bus.buf_col   <= '0;
            bus.buf_wdata <= '0;
        end else begin
            bus.buf_en <= wr_gnt_c || rd_gnt_c;
            if (wr_gnt_c) begin
                bus.buf_we    <= 1'b1;
                bus.buf_bank  <= bus.wr_bank;
                bus.buf_row   <= bus.wr_row;
                bus.buf_col   <= bus.wr_col;
                bus.buf_wdata <= bus.wr_data;
            end else if (rd_gnt_c) begin
                bus.buf_we   <= 1'b0;
                bus.buf_bank <= bus.rd_bank;
                bus.buf_row  <= bus.rd_row;
                bus.buf_col  <= bus.rd_col;
            end
        end
    end

    // Read return pipe (stage 0 aligns with buf_en) and block-end pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe          <= '0;
            tpipe          <= '0;
            wlast_q        <= 1'b0;
            bus.blkend     <= 1'b0;
            bus.rd_rvalid  <= 1'b0;
            bus.rd_rpsel_o <= '0;
            bus.rd_rdata   <= '0;
        end else begin
            vpipe         <= {vpipe[RD_LAT-2:0], rd_gnt_c};
            tpipe         <= {tpipe[RD_LAT-2:0], bus.rd_rpsel};
            wlast_q       <= wr_gnt_c && bus.wr_last;
            bus.blkend    <= wlast_q;
            bus.rd_rvalid <= vpipe[RD_LAT-1];
            if (vpipe[RD_LAT-1]) begin
                bus.rd_rpsel_o <= tpipe[RD_LAT-1];
                bus.rd_rdata   <= bus.buf_rdata;
            end
        end
    end
endmodule
